// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, fetch FSM encoding and PC step for the pipeline
package cpu_pkg;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetchState_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, stall hold and flush clear
module ifid_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic               hold,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  nextPc,
  input  logic [INSTR_W-1:0] nextInstr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);
  // a flush wins over a new load; a stall freezes the current contents
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (load && !hold) begin
      valid <= 1'b1;
      pc    <= nextPc;
      instr <= nextInstr;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, variable-latency imem handshake and IF/ID fill
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [6:0]         opcode_o,
  output logic               busy_o
);
  fetchState_t state, nextState;
  logic [ADDR_W-1:0] pc, savedTarget, pcInc;
  logic [INSTR_W-1:0] skid, ifidInstr;
  logic redirectPend, redirect, ack, ifidLoad;
  assign redirect  = branch_i && flush_i;
  assign ack       = (state == REQ) && imem_ack_i;
  assign pcInc     = pc + ADDR_W'(PC_STEP);
  assign ifidLoad  = (ack && !redirectPend) || (state == HOLD && start_i);
  assign ifidInstr = (state == HOLD) ? skid : imem_data_i;
  assign imem_addr_o = pc;
  assign opcode_o  = ifid_instr_o[6:0];
  ifid_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) uIfid (
    .clk_i, .rst_i,
    .load(ifidLoad), .hold(stall_i), .clear(flush_i),
    .nextPc(pc), .nextInstr(ifidInstr),
    .valid(ifid_valid_o), .pc(ifid_pc_o), .instr(ifid_instr_o)
  );
  // fetch FSM state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= nextState;
  // REQ only leaves on an ack; a stalled ack parks in HOLD unless it is being discarded
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = start_i ? REQ : IDLE;
      REQ:  nextState = !ack ? REQ : !start_i ? IDLE :
                        (stall_i && !redirect && !redirectPend) ? HOLD : REQ;
      HOLD: nextState = !start_i ? IDLE : (redirect || !stall_i) ? REQ : HOLD;
      default: nextState = IDLE;
    endcase
  end
  // request is raised only in REQ so the address stays put until the ack
  always_comb begin
    imem_req_o = (state == REQ);
    busy_o     = (state != IDLE);
  end
  // PC, deferred redirect and skid buffer; a redirect without ack waits for the in-flight word
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc           <= RESET_PC;
      savedTarget  <= '0;
      redirectPend <= 1'b0;
      skid         <= '0;
    end else if (state == REQ) begin
      if (ack) begin
        skid         <= imem_data_i;
        redirectPend <= 1'b0;
        pc <= redirect ? branch_target_i : redirectPend ? savedTarget : stall_i ? pc : pcInc;
      end else if (redirect) begin
        savedTarget  <= branch_target_i;
        redirectPend <= 1'b1;
      end
    end else if (state == HOLD) begin
      pc <= redirect ? branch_target_i : (start_i && !stall_i) ? pcInc : pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a transaction-level fetch model
module tb_fetch_unit;
  logic clk_i = 0, rst_i = 1, start_i = 0, stall_i = 0, branch_i = 0, flush_i = 0;
  logic [31:0] branch_target_i = 0;
  logic imem_req_o, imem_ack_i, ifid_valid_o, busy_o;
  logic [31:0] imem_addr_o, imem_data_i, ifid_pc_o, ifid_instr_o;
  logic [6:0] opcode_o;
  logic echo = 0, ackDrv = 0;
  logic [31:0] dataDrv = 0;
  int nChecks = 0, nFail = 0;
  assign imem_ack_i  = echo ? imem_req_o : ackDrv;
  assign imem_data_i = echo ? imem_addr_o : dataDrv;
  always #5 clk_i = ~clk_i;
  fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o),
    .ifid_instr_o(ifid_instr_o), .opcode_o(opcode_o), .busy_o(busy_o)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic idleInputs;
    start_i = 0; stall_i = 0; branch_i = 0; flush_i = 0; branch_target_i = 0;
    echo = 0; ackDrv = 0; dataDrv = 0;
  endtask
  task automatic doReset;
    idleInputs();
    rst_i = 0;
    tick();
    tick();
    rst_i = 1;
  endtask
  task automatic test_reset;
    start_i = 1;
    #1 rst_i = 0;
    #1;
    nChecks++;
    if ({imem_req_o, busy_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, imem_addr_o} !== '0) begin
      nFail++;
      $display("FAIL reset: req=%b busy=%b valid=%b pc=%h instr=%h op=%h addr=%h, want all 0",
               imem_req_o, busy_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, imem_addr_o);
    end
    doReset();
    nChecks++;
    if ({imem_req_o, busy_o, ifid_valid_o} !== 3'b000) begin
      nFail++;
      $display("FAIL reset_idle: req/busy/valid=%b want 000", {imem_req_o, busy_o, ifid_valid_o});
    end
  endtask
  task automatic test_back_to_back;
    doReset();
    start_i = 1; echo = 1;
    tick();
    nChecks++;
    if ({imem_req_o, imem_addr_o, ifid_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      nFail++;
      $display("FAIL b2b_first_req: req=%b addr=%h valid=%b want 1 0 0", imem_req_o, imem_addr_o, ifid_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = 32'(4 * k);
      tick();
      nChecks++;
      if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o} !== {1'b1, e, e, e[6:0]}) begin
        nFail++;
        $display("FAIL b2b_%0d: valid=%b pc=%h instr=%h op=%h want 1 %h %h %h",
                 k, ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, e, e, e[6:0]);
      end
    end
  endtask
  task automatic test_wait;
    doReset();
    start_i = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++;
      if ({imem_req_o, imem_addr_o, ifid_valid_o, busy_o} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
        nFail++;
        $display("FAIL wait_%0d: req=%b addr=%h valid=%b busy=%b want 1 0 0 1",
                 k, imem_req_o, imem_addr_o, ifid_valid_o, busy_o);
      end
    end
    ackDrv = 1; dataDrv = 32'hABCD_0013;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, imem_addr_o} !== {1'b1, 32'h0, 32'hABCD_0013, 7'h13, 32'h4}) begin
      nFail++;
      $display("FAIL wait_ack: valid=%b pc=%h instr=%h op=%h addr=%h want 1 0 abcd0013 13 4",
               ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, imem_addr_o);
    end
  endtask
  task automatic test_stall;
    doReset();
    start_i = 1;
    tick();
    ackDrv = 1; dataDrv = 32'h1111_0003;
    tick();
    stall_i = 1; dataDrv = 32'h2222_0023;
    tick();
    nChecks++;
    if ({imem_req_o, busy_o, ifid_valid_o, ifid_pc_o, ifid_instr_o} !== {1'b0, 1'b1, 1'b1, 32'h0, 32'h1111_0003}) begin
      nFail++;
      $display("FAIL stall_hold: req=%b busy=%b valid=%b pc=%h instr=%h want 0 1 1 0 11110003",
               imem_req_o, busy_o, ifid_valid_o, ifid_pc_o, ifid_instr_o);
    end
    ackDrv = 0;
    tick();
    nChecks++;
    if ({imem_req_o, ifid_pc_o, ifid_instr_o} !== {1'b0, 32'h0, 32'h1111_0003}) begin
      nFail++;
      $display("FAIL stall_hold2: req=%b pc=%h instr=%h want 0 0 11110003", imem_req_o, ifid_pc_o, ifid_instr_o);
    end
    stall_i = 0;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o, imem_addr_o} !== {1'b1, 32'h4, 32'h2222_0023, 1'b1, 32'h8}) begin
      nFail++;
      $display("FAIL stall_release: valid=%b pc=%h instr=%h req=%b addr=%h want 1 4 22220023 1 8",
               ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o, imem_addr_o);
    end
    flush_i = 1;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_instr_o, imem_addr_o} !== {1'b0, 32'h0, 32'h8}) begin
      nFail++;
      $display("FAIL flush_only: valid=%b instr=%h addr=%h want 0 0 8", ifid_valid_o, ifid_instr_o, imem_addr_o);
    end
  endtask
  task automatic test_branch_wait;
    doReset();
    start_i = 1;
    tick();
    ackDrv = 1; dataDrv = 32'h0000_0033;
    tick();
    ackDrv = 0; branch_i = 1; flush_i = 1; branch_target_i = 32'h40;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o} !== {1'b0, 32'h0, 1'b1, 32'h4}) begin
      nFail++;
      $display("FAIL br_wait_flush: valid=%b instr=%h req=%b addr=%h want 0 0 1 4",
               ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o);
    end
    branch_i = 0; flush_i = 0; branch_target_i = 0;
    tick();
    ackDrv = 1; dataDrv = 32'hDEAD_BEEF;
    tick();
    nChecks++;
    if ({ifid_valid_o, imem_addr_o} !== {1'b0, 32'h40}) begin
      nFail++;
      $display("FAIL br_late_ack: valid=%b addr=%h want 0 40", ifid_valid_o, imem_addr_o);
    end
    dataDrv = 32'h0000_0063;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_pc_o, opcode_o, imem_addr_o} !== {1'b1, 32'h40, 7'h63, 32'h44}) begin
      nFail++;
      $display("FAIL br_target_fetch: valid=%b pc=%h op=%h addr=%h want 1 40 63 44",
               ifid_valid_o, ifid_pc_o, opcode_o, imem_addr_o);
    end
  endtask
  task automatic test_branch_ack;
    doReset();
    start_i = 1;
    tick();
    ackDrv = 1; dataDrv = 32'h0000_0013;
    tick();
    dataDrv = 32'h5555_0013; stall_i = 1; branch_i = 1; flush_i = 1; branch_target_i = 32'h80;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o} !== {1'b0, 32'h0, 1'b1, 32'h80}) begin
      nFail++;
      $display("FAIL br_ack_stall: valid=%b instr=%h req=%b addr=%h want 0 0 1 80",
               ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o);
    end
  endtask
  task automatic test_wrap;
    doReset();
    start_i = 1;
    tick();
    ackDrv = 1; branch_i = 1; flush_i = 1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_i = 0; flush_i = 0; dataDrv = 32'h0000_0023;
    tick();
    nChecks++;
    if ({ifid_valid_o, ifid_pc_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      nFail++;
      $display("FAIL pc_wrap: valid=%b pc=%h addr=%h want 1 fffffffc 0", ifid_valid_o, ifid_pc_o, imem_addr_o);
    end
  endtask
  task automatic test_async_reset;
    doReset();
    start_i = 1;
    tick();
    tick();
    #2 rst_i = 0;
    #1;
    nChecks++;
    if ({imem_req_o, busy_o, ifid_valid_o, imem_addr_o} !== '0) begin
      nFail++;
      $display("FAIL async_rst: req=%b busy=%b valid=%b addr=%h want 0 0 0 0", imem_req_o, busy_o, ifid_valid_o, imem_addr_o);
    end
    ackDrv = 1; dataDrv = 32'h7777_7777;
    tick();
    nChecks++;
    if ({imem_req_o, ifid_valid_o, ifid_instr_o} !== {1'b0, 1'b0, 32'h0}) begin
      nFail++;
      $display("FAIL async_rst_ack: req=%b valid=%b instr=%h want 0 0 0", imem_req_o, ifid_valid_o, ifid_instr_o);
    end
    rst_i = 1; ackDrv = 0;
    tick();
    nChecks++;
    if ({imem_req_o, imem_addr_o, ifid_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      nFail++;
      $display("FAIL restart: req=%b addr=%h valid=%b want 1 0 0", imem_req_o, imem_addr_o, ifid_valid_o);
    end
  endtask
  task automatic test_random;
    bit mFetch, mHold, mPend, mV, st, stl, br, fl, ak, redir;
    logic [31:0] mPc, mTgt, mSkid, mIPc, mII, tgt, dat;
    doReset();
    mFetch = 0; mHold = 0; mPend = 0; mV = 0; mPc = 0; mTgt = 0; mSkid = 0; mIPc = 0; mII = 0;
    for (int c = 0; c < 3000; c++) begin
      nChecks++;
      if ({imem_req_o, busy_o} !== {mFetch, mFetch | mHold}) begin
        nFail++;
        $display("FAIL rnd_req c%0d: req/busy=%b want %b", c, {imem_req_o, busy_o}, {mFetch, mFetch | mHold});
      end
      if (mFetch) begin
        nChecks++;
        if (imem_addr_o !== mPc) begin
          nFail++;
          $display("FAIL rnd_addr c%0d: addr=%h want %h", c, imem_addr_o, mPc);
        end
      end
      nChecks++;
      if ({ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o} !== {mV, mIPc, mII, mII[6:0]}) begin
        nFail++;
        $display("FAIL rnd_ifid c%0d: valid=%b pc=%h instr=%h op=%h want %b %h %h %h",
                 c, ifid_valid_o, ifid_pc_o, ifid_instr_o, opcode_o, mV, mIPc, mII, mII[6:0]);
      end
      st  = $urandom_range(99) >= 3;
      stl = $urandom_range(99) < 30;
      c = c;
      begin
        int r;
        r = $urandom_range(99);
        br = r < 8;
        fl = r < 11;
      end
      tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      dat = $urandom;
      ak  = $urandom_range(1) == 1;
      start_i = st; stall_i = stl; branch_i = br; flush_i = fl; branch_target_i = tgt;
      ackDrv = ak; dataDrv = dat;
      redir = br && fl;
      if (fl) begin mV = 0; mIPc = 0; mII = 0; end
      if (!mFetch && !mHold) begin
        if (st) mFetch = 1;
      end else if (mFetch) begin
        if (ak) begin
          if (redir) mPc = tgt;
          else if (mPend) mPc = mTgt;
          else if (stl) begin mSkid = dat; mHold = st; end
          else begin
            if (!fl) begin mV = 1; mIPc = mPc; mII = dat; end
            mPc = mPc + 32'd4;
          end
          mPend = 0;
          mFetch = st && !mHold;
        end else if (redir) begin
          mPend = 1; mTgt = tgt;
        end
      end else begin
        if (redir) begin mPc = tgt; mHold = 0; mFetch = st; end
        else if (!st) mHold = 0;
        else if (!stl) begin
          if (!fl) begin mV = 1; mIPc = mPc; mII = mSkid; end
          mPc = mPc + 32'd4; mHold = 0; mFetch = 1;
        end
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_wait();
    test_stall();
    test_branch_wait();
    test_branch_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
